ir_queue: RTL and testbench
===========================

// Module: ir_queue
// PURPOSE
//  Parametrised instruction register / prefetch queue for the tiny8 core; successor to the single-entry IR.
//  Buffers fetched instruction words in a DEPTH-entry FIFO and decodes the head entry into opcode/rs/rd/delta/imm.
//  Exposes the word behind the head so that two-word (extended-immediate) instructions can be consumed in one pop.
//  Sits between the fetch unit (push side) and the control FSM (pop side); flushed on taken branches.
// PARAMETERS
//  WORD_W  8  instruction word width; must satisfy WORD_W > OPC_W + 2*REG_W
//  OPC_W   2  opcode field width
//  REG_W   2  register-specifier field width
//  DEPTH   4  FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1                    clock, all state updates on posedge
//  rst_n        in   1                    async active-low reset
//  flush        in   1                    sync discard of all entries
//  fetch_valid  in   1                    push request
//  fetch_data   in   WORD_W               word to push
//  fetch_ready  out  1                    queue can accept a push this cycle
//  out_valid    out  1                    head entry valid (count >= 1)
//  out_ready    in   1                    consumer pops the head this cycle
//  pop2         in   1                    with out_ready: pop head and next entry together
//  opcode       out  OPC_W                head[WORD_W-1 -: OPC_W]
//  rs           out  REG_W                next REG_W bits below opcode
//  rd           out  REG_W                next REG_W bits below rs
//  delta        out  WORD_W-OPC_W-2*REG_W head low bits below rd (delta2 at defaults)
//  imm          out  WORD_W-OPC_W-REG_W   head low bits below rs (imm4 at defaults)
//  nxt_valid    out  1                    entry behind head valid (count >= 2)
//  nxt_data     out  WORD_W               raw entry behind head
//  count        out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//  Reset (rst_n low, async): wr/rd pointers = 0, count = 0, storage need not clear.
//   While rst_n low: fetch_ready=0, out_valid=0, nxt_valid=0; all decoded fields and nxt_data = 0.
//  fetch_ready = rst_n && (count < DEPTH); no combinational path from out_ready/pop2 to fetch_ready.
//  Push: fetch_valid && fetch_ready at posedge writes fetch_data at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  Latency: pushed word visible at output the cycle after its push edge; no same-cycle bypass into empty queue.
//  Pop1: out_valid && out_ready && !pop2 -> rd_ptr += 1.
//  Pop2: out_ready && pop2 && nxt_valid -> rd_ptr += 2 (mod DEPTH).
//   pop2 with count < 2: no pop, no state change (consumer must wait for nxt_valid).
//  out_ready with out_valid=0: ignored.
//  count next = count + push - pops; simultaneous push and pop legal at any fill level where each is individually allowed.
//  Full (count==DEPTH): push blocked even if a pop occurs in the same cycle.
//  Empty (count==0): out_valid=0; decoded fields and nxt_data forced 0.
//  count==1: nxt_valid=0 and nxt_data forced 0.
//  flush: at posedge, pointers and count return to 0; overrides push and pop in the same cycle.
//   Outputs read empty the following cycle.
//  Decode is purely combinational from the stored head.
//  All outputs except fetch_ready/valids depend only on registered state.
//  Pointers are log2(DEPTH) bits and wrap naturally. count saturates by construction and never exceeds DEPTH.
// TESTING
//  Reset, push 8'hB6 -> next cycle out_valid=1, opcode=2, rs=3, rd=1, delta=2, imm=6, count=1, nxt_valid=0.
//  Push 4 words with out_ready=0 -> count=4, fetch_ready=0; 5th fetch_valid dropped, contents unchanged.
//  Full queue, push+pop1 same cycle -> push rejected, count=3. Then push+pop1 -> count stays 3, order preserved.
//  Queue {A1,7F}: pop2=1,out_ready=1 -> count=0 next cycle. With only {A1}: pop2 -> no change, count=1.
//  Push 6 and pop 6 interleaved across wrap -> FIFO order exact; flush with push+pop same cycle -> count=0, out_valid=0.
//  Deassert rst_n mid-stream with count=3 -> outputs 0 immediately (async); after release count=0, fetch_ready=1.

Source files
------------

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - tiny8 instruction prefetch queue with head decode and one-word lookahead
module ir_queue #(
    parameter int WORD_W = 8,
    parameter int OPC_W  = 2,
    parameter int REG_W  = 2,
    parameter int DEPTH  = 4,
    localparam int DELTA_W = WORD_W - OPC_W - 2 * REG_W,
    localparam int IMM_W   = WORD_W - OPC_W - REG_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               fetch_valid,
    input  logic [WORD_W-1:0]  fetch_data,
    output logic               fetch_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               pop2,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rd,
    output logic [DELTA_W-1:0] delta,
    output logic [IMM_W-1:0]   imm,
    output logic               nxt_valid,
    output logic [WORD_W-1:0]  nxt_data,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] head;
    logic              push;
    logic              pop_one;
    logic              pop_two;

    // Full blocks the push even when a pop frees a slot this cycle, keeping
    // fetch_ready free of any path from the consumer side.
    assign fetch_ready = rst_n && (cnt < FULL_CNT);
    assign out_valid   = (cnt != '0);
    assign nxt_valid   = (cnt >= TWO_CNT);
    assign count       = cnt;

    assign push    = fetch_valid && fetch_ready;
    assign pop_one = out_valid && out_ready && !pop2;
    assign pop_two = out_ready && pop2 && nxt_valid;

    assign head     = out_valid ? mem[rd_ptr] : '0;
    assign nxt_data = nxt_valid ? mem[rd_ptr + PTR_W'(1)] : '0;

    assign opcode = head[WORD_W-1 -: OPC_W];
    assign rs     = head[WORD_W-OPC_W-1 -: REG_W];
    assign rd     = head[WORD_W-OPC_W-REG_W-1 -: REG_W];
    assign delta  = head[DELTA_W-1:0];
    assign imm    = head[IMM_W-1:0];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= fetch_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_one) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end else if (pop_two) begin
                rd_ptr <= rd_ptr + PTR_W'(2);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'({pop_two, pop_one});
        end
    end

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - self-checking bench for ir_queue against a queue-based model
module tb_ir_queue;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       fetch_valid;
    logic [7:0] fetch_data;
    logic       fetch_ready;
    logic       out_valid;
    logic       out_ready;
    logic       pop2;
    logic [1:0] opcode;
    logic [1:0] rs;
    logic [1:0] rd;
    logic [1:0] delta;
    logic [3:0] imm;
    logic       nxt_valid;
    logic [7:0] nxt_data;
    logic [2:0] count;

    int tests;
    int errors;
    logic [7:0] q[$];

    ir_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .out_valid(out_valid), .out_ready(out_ready), .pop2(pop2),
        .opcode(opcode), .rs(rs), .rd(rd), .delta(delta), .imm(imm),
        .nxt_valid(nxt_valid), .nxt_data(nxt_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         fv;
        logic [7:0] fd;
        bit         ordy;
        bit         p2;
        bit         fl;
        int         ecnt;
        bit         efr;
        logic [7:0] ehead;
        logic [7:0] enxt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit fv, logic [7:0] fd, bit ordy, bit p2, bit fl,
                                int ecnt, bit efr, logic [7:0] ehead, logic [7:0] enxt);
        vec_t v;
        v.fv = fv; v.fd = fd; v.ordy = ordy; v.p2 = p2; v.fl = fl;
        v.ecnt = ecnt; v.efr = efr; v.ehead = ehead; v.enxt = enxt;
        return v;
    endfunction

    task automatic cmp(input string tag, input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input int ecnt, input bit efr,
                             input int ehead, input int enxt);
        cmp(tag, "count", int'(count), ecnt);
        cmp(tag, "fetch_ready", int'(fetch_ready), int'(efr));
        cmp(tag, "out_valid", int'(out_valid), int'(ecnt >= 1));
        cmp(tag, "nxt_valid", int'(nxt_valid), int'(ecnt >= 2));
        cmp(tag, "opcode", int'(opcode), ehead / 64);
        cmp(tag, "rs", int'(rs), (ehead / 16) % 4);
        cmp(tag, "rd", int'(rd), (ehead / 4) % 4);
        cmp(tag, "delta", int'(delta), ehead % 4);
        cmp(tag, "imm", int'(imm), ehead % 16);
        cmp(tag, "nxt_data", int'(nxt_data), enxt);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        check_exp(tag, n, n < 4, (n >= 1) ? int'(q[0]) : 0, (n >= 2) ? int'(q[1]) : 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, settle just after.
    task automatic cycle(input bit fv, input logic [7:0] fd, input bit ordy,
                         input bit p2, input bit fl);
        int n;
        bit psh;
        fetch_valid = fv; fetch_data = fd; out_ready = ordy; pop2 = p2; flush = fl;
        @(posedge clk);
        n = q.size();
        if (fl) begin
            q.delete();
        end else begin
            psh = fv && (n < 4);
            if (ordy && p2) begin
                if (n >= 2) begin
                    void'(q.pop_front());
                    void'(q.pop_front());
                end
            end else if (ordy && n >= 1) begin
                void'(q.pop_front());
            end
            if (psh) q.push_back(fd);
        end
        #1;
        fetch_valid = 1'b0; out_ready = 1'b0; pop2 = 1'b0; flush = 1'b0;
    endtask

    initial begin
        tests = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0; fetch_valid = 1'b0; fetch_data = 8'h00; out_ready = 1'b0; pop2 = 1'b0;

        #2;
        check_exp("in_reset", 0, 1'b0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_exp("after_reset", 0, 1'b1, 0, 0);

        vecs.push_back(mk(1, 8'hB6, 0, 0, 0, 1, 1, 8'hB6, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 1, 8'h11, 8'h00));
        vecs.push_back(mk(1, 8'h22, 0, 0, 0, 2, 1, 8'h11, 8'h22));
        vecs.push_back(mk(1, 8'h33, 0, 0, 0, 3, 1, 8'h11, 8'h22));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0, 4, 0, 8'h11, 8'h22));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0, 4, 0, 8'h11, 8'h22));
        vecs.push_back(mk(1, 8'h66, 1, 0, 0, 3, 1, 8'h22, 8'h33));
        vecs.push_back(mk(1, 8'h77, 1, 0, 0, 3, 1, 8'h33, 8'h44));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 2, 1, 8'h44, 8'h77));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 1, 1, 8'hA1, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 8'hA1, 8'h00));
        vecs.push_back(mk(1, 8'h7F, 0, 0, 0, 2, 1, 8'hA1, 8'h7F));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 1, 1, 8'h5A, 8'h00));
        vecs.push_back(mk(1, 8'h5B, 0, 0, 0, 2, 1, 8'h5A, 8'h5B));
        vecs.push_back(mk(1, 8'h5C, 1, 0, 1, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mk(1, 8'hC3, 0, 0, 0, 1, 1, 8'hC3, 8'h00));
        vecs.push_back(mk(1, 8'hD4, 1, 1, 0, 2, 1, 8'hC3, 8'hD4));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].fv, vecs[i].fd, vecs[i].ordy, vecs[i].p2, vecs[i].fl);
            check_exp($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].efr,
                      int'(vecs[i].ehead), int'(vecs[i].enxt));
        end

        // Six pushes and pops interleaved so both pointers wrap.
        cycle(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'h10 + 8'(i), i > 0, 0, 0);
            check_model($sformatf("wrap_push%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 8'h00, 1, 0, 0);
            check_model($sformatf("wrap_drain%0d", i));
        end

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset landing mid-cycle with three entries queued.
        cycle(0, 8'h00, 0, 0, 1);
        cycle(1, 8'hE1, 0, 0, 0);
        cycle(1, 8'hE2, 0, 0, 0);
        cycle(1, 8'hE3, 0, 0, 0);
        check_model("pre_async_reset");
        #2 rst_n = 1'b0;
        q.delete();
        #1 check_exp("async_reset", 0, 1'b0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_exp("post_reset", 0, 1'b1, 0, 0);
        @(negedge clk);
        cycle(1, 8'h9C, 0, 0, 0);
        check_model("post_reset_push");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
